// File: rtl/uart_rsp_collector.sv
// Host-side UART response receiver: deserializes one- or two-byte responses
// (LSB frame first) into a 16-bit word with single-cycle status pulses.
module uart_rsp_collector #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ser_in,
    input  logic                    par_en,
    input  logic                    par_typ,
    input  logic                    exp_len,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_vld,
    output logic                    par_err,
    output logic                    stp_err,
    output logic                    tmo_err,
    output logic                    busy
);

    localparam int unsigned RSP_W     = 2 * DATA_WIDTH;
    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TMO_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TMO_CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   stage_q, stage_d;
    logic                    byte_idx_q, byte_idx_d;
    logic                    len_q, len_d;
    logic                    frm_par_en_q, frm_par_en_d;
    logic                    frm_par_typ_q, frm_par_typ_d;
    logic                    par_bad_q, par_bad_d;
    logic [RSP_W-1:0]        rsp_data_d;
    logic                    rsp_vld_d, par_err_d, stp_err_d, tmo_err_d, busy_d;
    logic                    par_exp_c;

    // Expected parity bit: even parity for typ 0, odd parity for typ 1.
    assign par_exp_c = (^shift_q) ^ frm_par_typ_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            shift_q       <= '0;
            stage_q       <= '0;
            byte_idx_q    <= 1'b0;
            len_q         <= 1'b0;
            frm_par_en_q  <= 1'b0;
            frm_par_typ_q <= 1'b0;
            par_bad_q     <= 1'b0;
            rsp_data      <= '0;
            rsp_vld       <= 1'b0;
            par_err       <= 1'b0;
            stp_err       <= 1'b0;
            tmo_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            shift_q       <= shift_d;
            stage_q       <= stage_d;
            byte_idx_q    <= byte_idx_d;
            len_q         <= len_d;
            frm_par_en_q  <= frm_par_en_d;
            frm_par_typ_q <= frm_par_typ_d;
            par_bad_q     <= par_bad_d;
            rsp_data      <= rsp_data_d;
            rsp_vld       <= rsp_vld_d;
            par_err       <= par_err_d;
            stp_err       <= stp_err_d;
            tmo_err       <= tmo_err_d;
            busy          <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        shift_d       = shift_q;
        stage_d       = stage_q;
        byte_idx_d    = byte_idx_q;
        len_d         = len_q;
        frm_par_en_d  = frm_par_en_q;
        frm_par_typ_d = frm_par_typ_q;
        par_bad_d     = par_bad_q;
        rsp_data_d    = rsp_data;
        rsp_vld_d     = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        tmo_err_d     = 1'b0;
        busy_d        = busy;

        case (state_q)
            S_IDLE: begin
                if (!ser_in) begin
                    state_d       = S_DATA;
                    bit_cnt_d     = '0;
                    byte_idx_d    = 1'b0;
                    len_d         = exp_len;
                    frm_par_en_d  = par_en;
                    frm_par_typ_d = par_typ;
                    par_bad_d     = 1'b0;
                    busy_d        = 1'b1;
                end
            end

            S_DATA: begin
                shift_d = {ser_in, shift_q[DATA_WIDTH-1:1]};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = frm_par_en_q ? S_PARITY : S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end

            S_PARITY: begin
                par_bad_d = (ser_in != par_exp_c);
                state_d   = S_STOP;
            end

            S_STOP: begin
                // Parity failure outranks a bad stop bit.
                if (par_bad_q) begin
                    par_err_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (!ser_in) begin
                    stp_err_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (byte_idx_q == len_q) begin
                    rsp_vld_d  = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                    rsp_data_d = byte_idx_q ? {shift_q, stage_q}
                                            : {{DATA_WIDTH{1'b0}}, shift_q};
                end else begin
                    stage_d    = shift_q;
                    byte_idx_d = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (!ser_in) begin
                    state_d       = S_DATA;
                    bit_cnt_d     = '0;
                    frm_par_en_d  = par_en;
                    frm_par_typ_d = par_typ;
                    par_bad_d     = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_cnt_d = '0;
                    tmo_err_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rsp_collector.sv
// Randomized bench for uart_rsp_collector: builds a line stream from response
// transactions and predicts every cycle's pulses, BUSY and RSP_DATA.
module tb_uart_rsp_collector;

    localparam int unsigned DW    = 8;
    localparam int          TMO   = 32;
    localparam int          N_MAX = 8192;
    localparam logic [3:0]  K_VLD = 4'b0001;
    localparam logic [3:0]  K_PAR = 4'b0010;
    localparam logic [3:0]  K_STP = 4'b0100;
    localparam logic [3:0]  K_TMO = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ser_in;
    logic        par_en;
    logic        par_typ;
    logic        exp_len;
    logic [15:0] rsp_data;
    logic        rsp_vld;
    logic        par_err;
    logic        stp_err;
    logic        tmo_err;
    logic        busy;

    uart_rsp_collector #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ser_in   (ser_in),
        .par_en   (par_en),
        .par_typ  (par_typ),
        .exp_len  (exp_len),
        .rsp_data (rsp_data),
        .rsp_vld  (rsp_vld),
        .par_err  (par_err),
        .stp_err  (stp_err),
        .tmo_err  (tmo_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;

    // Stream index j: line value sampled at edge j; expectations observed
    // on the falling edge before j is driven (i.e. after edge j-1).
    bit          line_v [N_MAX];
    bit          cfg_pe [N_MAX];
    bit          cfg_pt [N_MAX];
    bit          cfg_el [N_MAX];
    logic [3:0]  ekind  [N_MAX];
    logic [15:0] eval   [N_MAX];
    bit          ebusy  [N_MAX];
    int          n_len;
    logic [15:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic clear_stream();
        for (int i = 0; i < N_MAX; i++) begin
            ekind[i] = '0;
            eval[i]  = '0;
            ebusy[i] = 1'b0;
        end
        n_len = 0;
    endtask

    task automatic push(input bit b, input bit pe, input bit pt, input bit el);
        line_v[n_len] = b;
        cfg_pe[n_len] = pe;
        cfg_pt[n_len] = pt;
        cfg_el[n_len] = el;
        n_len++;
    endtask

    task automatic push_idle(input int cnt);
        for (int i = 0; i < cnt; i++) push(1'b1, rb(), rb(), rb());
    endtask

    // Controls carry real values only on the start bit; noise elsewhere.
    task automatic push_frame(input logic [7:0] d, input bit pe, input bit pt,
                              input bit pbad, input bit sbad, input bit el);
        bit par_bit;
        push(1'b0, pe, pt, el);
        for (int i = 0; i < int'(DW); i++) push(d[i], rb(), rb(), rb());
        par_bit = pt ? ~(^d) : (^d);
        if (pe) push(par_bit ^ pbad, rb(), rb(), rb());
        push(~sbad, rb(), rb(), rb());
    endtask

    task automatic add_txn(input bit el,
                           input logic [7:0] d0, input bit pe0, input bit pt0,
                           input bit pb0, input bit sb0,
                           input logic [7:0] d1, input bit pe1, input bit pt1,
                           input bit pb1, input bit sb1,
                           input int gap, input int tail);
        int          base;
        int          last;
        int          p;
        logic [3:0]  kind;
        logic [15:0] val;
        base = n_len;
        val  = '0;
        push_frame(d0, pe0, pt0, pb0, sb0, el);
        last = n_len - 1;
        if (pe0 && pb0)      kind = K_PAR;
        else if (sb0)        kind = K_STP;
        else if (!el) begin
            kind = K_VLD;
            val  = {8'h00, d0};
        end else if (gap >= TMO) begin
            push_idle(TMO);
            last = n_len - 1;
            kind = K_TMO;
        end else begin
            push_idle(gap);
            push_frame(d1, pe1, pt1, pb1, sb1, rb());
            last = n_len - 1;
            if (pe1 && pb1)  kind = K_PAR;
            else if (sb1)    kind = K_STP;
            else begin
                kind = K_VLD;
                val  = {d1, d0};
            end
        end
        p = last + 1;
        for (int j = base + 1; j < p; j++) ebusy[j] = 1'b1;
        ekind[p] = kind;
        eval[p]  = val;
        push_idle(tail);
    endtask

    task automatic add_random(input int cnt);
        int gap;
        for (int k = 0; k < cnt; k++) begin
            gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TMO - 3, TMO + 3))
                                               : int'($urandom_range(0, 3));
            add_txn(rb(), 8'($urandom), rb(), rb(), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0),
                    8'($urandom), rb(), rb(), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0),
                    gap, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic run_stream();
        logic [3:0] obs;
        push_idle(3);
        for (int j = 0; j < n_len; j++) begin
            @(negedge clk);
            obs = {tmo_err, stp_err, par_err, rsp_vld};
            if (obs != 4'b0000 || ekind[j] != 4'b0000)
                check("pulse", 32'(obs), 32'(ekind[j]));
            if (ekind[j] == K_VLD) m_data = eval[j];
            check("busy", 32'(busy), 32'(ebusy[j]));
            check("rsp_data", 32'(rsp_data), 32'(m_data));
            ser_in  = line_v[j];
            par_en  = cfg_pe[j];
            par_typ = cfg_pt[j];
            exp_len = cfg_el[j];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
        check({tag, "_vld"},      32'(rsp_vld),  32'h0);
        check({tag, "_par_err"},  32'(par_err),  32'h0);
        check({tag, "_stp_err"},  32'(stp_err),  32'h0);
        check({tag, "_tmo_err"},  32'(tmo_err),  32'h0);
        check({tag, "_busy"},     32'(busy),     32'h0);
    endtask

    initial begin
        logic [7:0] d;
        rst_n   = 1'b0;
        ser_in  = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        exp_len = 1'b0;
        m_data  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed cases followed by random transactions.
        clear_stream();
        push_idle(2);
        add_txn(0, 8'h95, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2);
        add_txn(1, 8'h0F, 1, 0, 0, 0, 8'h01, 1, 0, 0, 0, 0, 1);
        add_txn(1, 8'h0F, 1, 1, 0, 0, 8'h01, 1, 1, 0, 0, 0, 0);
        add_txn(0, 8'h95, 1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        add_txn(0, 8'h3C, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3);
        add_txn(0, 8'hA5, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        add_txn(0, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        add_txn(1, 8'h0F, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, TMO, 0);
        add_txn(1, 8'h34, 1, 0, 0, 0, 8'h12, 1, 0, 0, 0, 0, 1);
        add_txn(1, 8'h77, 0, 0, 0, 0, 8'h88, 1, 1, 0, 0, TMO - 1, 0);
        add_txn(0, 8'h5A, 1, 1, 1, 1, 8'h00, 0, 0, 0, 0, 0, 1);
        add_txn(1, 8'hC3, 1, 0, 0, 0, 8'h3C, 1, 0, 1, 0, 3, 1);
        add_txn(1, 8'hC3, 1, 0, 0, 0, 8'h3C, 0, 0, 0, 1, 0, 1);
        add_random(40);
        run_stream();

        // Reset asserted while data bit 4 of a frame is on the line.
        d = 8'hB6;
        @(negedge clk);
        ser_in  = 1'b0;
        par_en  = 1'b1;
        par_typ = 1'b0;
        exp_len = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ser_in = d[i];
        end
        check("busy_before_rst", 32'(busy), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        ser_in = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("rst_hold");
        rst_n  = 1'b1;
        m_data = '0;

        clear_stream();
        push_idle(1);
        add_txn(0, 8'h55, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        add_random(20);
        run_stream();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rsp_collector.md
# uart_rsp_collector

Bit-rate UART response receiver for the host side of the system's serial command link. It watches the system's serial output line, deserializes one UART frame per byte, checks parity and stop bits, and assembles one-byte responses (register-file read) or two-byte responses (ALU result, LSB frame first) into a single 16-bit word with a valid pulse. It sits opposite the system's command receiver and is the in-silicon counterpart of the command frame generator used in system-level verification.

## Interface

- DATA_WIDTH, 8, bits per UART frame payload
- TIMEOUT, 32, idle-line cycles allowed between the two frames of a two-byte response before the response is aborted

- CLK  in  1  bit-rate clock; exactly one UART bit per cycle, line sampled on posedge
- RST  in  1  reset; one clock, asynchronous, active-low
- SER_IN  in  1  serial line, idle high
- PAR_EN  in  1  1 = frame carries a parity bit after the data bits
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- EXP_LEN  in  1  0 = one-byte response, 1 = two-byte response; sampled at the first start bit
- RSP_DATA  out  2*DATA_WIDTH  assembled response, {byte1, byte0}; upper byte 0 for one-byte responses
- RSP_VLD  out  1  one-cycle pulse, RSP_DATA valid
- PAR_ERR  out  1  one-cycle pulse, parity mismatch, response dropped
- STP_ERR  out  1  one-cycle pulse, stop bit sampled 0, response dropped
- TMO_ERR  out  1  one-cycle pulse, second frame did not start within TIMEOUT cycles
- BUSY  out  1  high from first start bit until response completes or aborts

## Operation

- States: IDLE, DATA, PARITY, STOP, WAIT.
- IDLE: SER_IN sampled 0 -> DATA, bit counter = 0, byte index = 0, EXP_LEN latched.
- DATA: DATA_WIDTH cycles, shift SER_IN in LSB first. After last bit -> PARITY if PAR_EN else STOP. PAR_EN/PAR_TYP are sampled at each start bit and held for the frame.
- PARITY: expected bit = ^data for PAR_TYP=0, ~^data for PAR_TYP=1. Mismatch recorded; -> STOP.
- STOP: sample SER_IN. Outcomes, in priority order:
  - parity mismatch -> PAR_ERR pulse (STP_ERR not asserted even if stop bit is also bad), drop, IDLE.
  - SER_IN = 0 -> STP_ERR pulse, drop, IDLE.
  - good frame, final byte (index == EXP_LEN) -> store byte, RSP_VLD pulse, IDLE.
  - good frame, byte 0 of two-byte response -> store as RSP_DATA[7:0] staging, WAIT, idle counter = 0.
- WAIT: SER_IN = 0 -> DATA for byte 1. Otherwise counter increments; reaching TIMEOUT -> TMO_ERR pulse, drop, IDLE.
- RSP_DATA updates only together with RSP_VLD and holds its value otherwise; dropped responses never alter it.
- A start bit may be sampled on the cycle immediately after the stop-bit sample (back-to-back frames); no gap cycle required.
- At most one of RSP_VLD, PAR_ERR, STP_ERR, TMO_ERR is high in any cycle.

## Timing

- Reset: state IDLE, RSP_DATA = 0, RSP_VLD = PAR_ERR = STP_ERR = TMO_ERR = BUSY = 0, all counters 0.
- Reset mid-frame or mid-WAIT: immediate abort, no error pulse, outputs to reset values.
- Start bit sampled at edge 0: data bits at edges 1..8, parity at edge 9, stop at edge 10 (stop at edge 9 with PAR_EN=0).
- Status pulses (RSP_VLD / *_ERR) are registered, high for the single cycle after the stop-sample edge (or the TIMEOUT-th WAIT edge).
- Two-byte latency with parity, back-to-back frames: RSP_VLD 22 cycles after the first start-bit edge.
- BUSY rises the cycle after the first start-bit edge and falls in the same cycle the status pulse rises.
- Glitch-free line assumed: no start-bit re-verification, no oversampling.

## Test plan

- PAR_EN=1, PAR_TYP=0, EXP_LEN=0, frame 0x95 with parity 0, stop 1 -> RSP_DATA=0x0095, RSP_VLD one cycle, 11 cycles after start edge.
- PAR_EN=1, PAR_TYP=0, EXP_LEN=1, frames 0x0F (parity 0) then 0x01 (parity 1) back-to-back -> RSP_DATA=0x010F, RSP_VLD at 22 cycles; repeat with PAR_TYP=1 and inverted parity bits -> same result.
- EXP_LEN=0, frame 0x95 with parity bit 1 (even) -> PAR_ERR pulse, no RSP_VLD, RSP_DATA unchanged; next valid frame 0x3C -> RSP_DATA=0x003C.
- PAR_EN=0, frame 0xA5 with stop bit 0 -> STP_ERR pulse at 10 cycles, IDLE; following good 0xA5 frame -> RSP_DATA=0x00A5.
- EXP_LEN=1, good frame 0x0F then line idle high 32 cycles -> TMO_ERR pulse, BUSY low, no RSP_VLD; subsequent two-byte response 0x34,0x12 -> RSP_DATA=0x1234.
- RST low during data bit 4 of a frame -> all outputs 0 immediately, no error pulse; after release, full frame 0x55 (EXP_LEN=0) -> RSP_DATA=0x0055.
